// File: rtl/bcd_to_bin_seq.sv
// Iterative packed-BCD to binary converter (reverse double-dabble), start/done handshake.
// Optional macro BCD2BIN_FAST_EN: two shift/correct steps per clock in CONV.
module bcd_to_bin_seq #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIGITS*4-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  ovf
);

  localparam int SW = DIGITS*4 + BIN_W;
  localparam int CW = $clog2(BIN_W + 2) + 1;

  // Handshake: start is taken only on an edge where the FSM is IDLE; done is a
  // one-cycle pulse after which bin_out/err/ovf stay stable until the next accept.
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_next;
  logic [SW-1:0]   sreg, sreg_step;
  logic [CW-1:0]   cnt, cnt_step;
  logic            err_flag, last_step, bad_digit;

  // One step: halve the whole register, then pull 3 from any digit that just
  // received a borrowed bit (10/2 = 5 = 8 - 3).
  function automatic logic [SW-1:0] step(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (r[BIN_W + 4*d + 3])
        r[BIN_W + 4*d +: 4] = r[BIN_W + 4*d +: 4] - 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    bad_digit = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d + 3] && (bcd_in[4*d + 2] || bcd_in[4*d + 1]))
        bad_digit = 1'b1;
    end
  end

  always_comb begin
    sreg_step = step(sreg);
    cnt_step  = cnt + CW'(1);
    last_step = (cnt == CW'(BIN_W - 1));
`ifdef BCD2BIN_FAST_EN
    // An odd BIN_W leaves a single step for the final cycle.
    if (cnt != CW'(BIN_W - 1)) begin
      sreg_step = step(step(sreg));
      cnt_step  = cnt + CW'(2);
    end
    last_step = ((int'(cnt) + 2) >= BIN_W);
`endif
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CONV;
      CONV: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      bin_out  <= '0;
      err      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          sreg     <= {bcd_in, {BIN_W{1'b0}}};
          cnt      <= '0;
          err_flag <= bad_digit;
        end
        CONV: begin
          sreg <= sreg_step;
          cnt  <= cnt_step;
          if (last_step) begin
            bin_out <= err_flag ? '0 : sreg_step[BIN_W-1:0];
            err     <= err_flag;
            ovf     <= |sreg_step[SW-1:BIN_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Bench for bcd_to_bin_seq: default instance (5 digits, 17 bits) and a small
// instance (3 digits, 8 bits), checked against a decimal-arithmetic model.
module tb_bcd_to_bin_seq;

  localparam int DG  = 5;
  localparam int BW  = 17;
  localparam int SDG = 3;
  localparam int SBW = 8;
  localparam int NH  = 80;

`ifdef BCD2BIN_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0;
  logic [DG*4-1:0] bcd_in = '0;
  logic            busy, done, err, ovf;
  logic [BW-1:0]   bin_out;

  logic             s_start = 1'b0;
  logic [SDG*4-1:0] s_bcd = '0;
  logic             s_busy, s_done, s_err, s_ovf;
  logic [SBW-1:0]   s_bin;

  bcd_to_bin_seq #(.DIGITS(DG), .BIN_W(BW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err), .ovf(ovf)
  );

  bcd_to_bin_seq #(.DIGITS(SDG), .BIN_W(SBW)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .bcd_in(s_bcd),
    .busy(s_busy), .done(s_done), .bin_out(s_bin), .err(s_err), .ovf(s_ovf)
  );

  int checks = 0;
  int errors = 0;
  logic [BW+1:0]  exp_q[$];
  logic [SBW+1:0] s_exp_q[$];
  logic [DG*4-1:0] hist [0:NH-1];

  task automatic check(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: clocks from start sample to first done sample, inclusive
  function automatic int lat_of(input int bw);
    return FAST ? (bw + 1) / 2 + 1 : bw + 1;
  endfunction

  // returns {ovf, err, bin} packed at bit positions bw+1, bw, [bw-1:0]
  function automatic logic [63:0] model(input logic [31:0] b, input int dg, input int bw);
    longint v, p, lim;
    logic bad;
    logic [63:0] r;
    v = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < dg; i++) begin
      v += longint'(b[4*i +: 4]) * p;
      p *= 10;
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    lim = longint'(1) << bw;
    r = bad ? 64'd0 : 64'(v % lim);
    r[bw]   = bad;
    r[bw+1] = (v >= lim);
    return r;
  endfunction

  function automatic logic [31:0] rand_bcd(input int dg, input bit allow_bad);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < dg; i++)
      b[4*i +: 4] = 4'($urandom_range(0, allow_bad ? 15 : 9));
    return b;
  endfunction

  // driver + scoreboard for the default instance
  task automatic run_big(input logic [DG*4-1:0] b);
    logic [63:0] m;
    logic [BW+1:0] e;
    int n, nb;
    m = model(32'(b), DG, BW);
    exp_q.push_back(m[BW+1:0]);
    @(negedge clk); bcd_in = b; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; bcd_in = 20'($urandom);
    n = 1; nb = busy ? 1 : 0;
    while (!done && n < 4*BW) begin
      @(posedge clk); #1; n++;
      if (busy) nb++;
    end
    check("latency", n === lat_of(BW), n, lat_of(BW));
    check("busy_cycles", nb === lat_of(BW) - 1, nb, lat_of(BW) - 1);
    e = exp_q.pop_front();
    check("bin_out", bin_out === e[BW-1:0], bin_out, e[BW-1:0]);
    check("err", err === e[BW], err, e[BW]);
    check("ovf", ovf === e[BW+1], ovf, e[BW+1]);
    check("busy_and_done", (busy & done) === 1'b0, busy & done, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done === 1'b0, done, 0);
    check("bin_out_held", bin_out === e[BW-1:0], bin_out, e[BW-1:0]);
  endtask

  task automatic run_small(input logic [SDG*4-1:0] b);
    logic [63:0] m;
    logic [SBW+1:0] e;
    int n;
    m = model(32'(b), SDG, SBW);
    s_exp_q.push_back(m[SBW+1:0]);
    @(negedge clk); s_bcd = b; s_start = 1'b1;
    @(posedge clk); #1; s_start = 1'b0;
    n = 1;
    while (!s_done && n < 4*SBW) begin
      @(posedge clk); #1; n++;
    end
    check("s_latency", n === lat_of(SBW), n, lat_of(SBW));
    e = s_exp_q.pop_front();
    check("s_bin_out", s_bin === e[SBW-1:0], s_bin, e[SBW-1:0]);
    check("s_err", s_err === e[SBW], s_err, e[SBW]);
    check("s_ovf", s_ovf === e[SBW+1], s_ovf, e[SBW+1]);
    @(posedge clk); #1;
    check("s_done_one_cycle", s_done === 1'b0, s_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, last_c, acc, ndone, expd;
    logic [63:0] m;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy === 1'b0, busy, 0);
    check("rst_done", done === 1'b0, done, 0);
    check("rst_bin_out", bin_out === 17'd0, bin_out, 0);
    check("rst_err", err === 1'b0, err, 0);
    check("rst_ovf", ovf === 1'b0, ovf, 0);
    @(negedge clk); rst_n = 1'b1;

    // directed operands
    run_big(20'h00000);
    run_big(20'h99999);
    run_big(20'h00010);
    run_big(20'h12345);
    run_big(20'h000A5);
    run_big(20'h00042);
    run_big(20'hF0000);
    for (int i = 0; i < 8; i++) run_big(20'(rand_bcd(DG, i >= 6)));

    // 8-bit result boundary
    run_small(12'h255);
    run_small(12'h256);
    run_small(12'h999);
    for (int i = 0; i < 4; i++) run_small(12'(rand_bcd(SDG, i == 3)));

    // start held high, operand changing every cycle
    last_c = -1; ndone = 0;
    for (int c = 0; c < NH; c++) begin
      @(negedge clk);
      bcd_in = 20'(rand_bcd(DG, c % 7 == 3));
      hist[c] = bcd_in;
      start = 1'b1;
      @(posedge clk); #1;
      check("held_busy_and_done", (busy & done) === 1'b0, busy & done, 0);
      if (done) begin
        ndone++;
        acc = c - (lat_of(BW) - 1);
        if (acc >= 0) begin
          m = model(32'(hist[acc]), DG, BW);
          check("held_bin_out", bin_out === m[BW-1:0], bin_out, m[BW-1:0]);
          check("held_err", err === m[BW], err, m[BW]);
          check("held_ovf", ovf === m[BW+1], ovf, m[BW+1]);
        end
        if (last_c >= 0)
          check("held_spacing", (c - last_c) === lat_of(BW) + 1, c - last_c, lat_of(BW) + 1);
        last_c = c;
      end
    end
    @(negedge clk); start = 1'b0;
    expd = (NH - lat_of(BW)) / (lat_of(BW) + 1) + 1;
    check("held_done_count", ndone === expd, ndone, expd);
    repeat (lat_of(BW) + 2) @(posedge clk);

    // reset five clocks into a conversion
    run_big(20'h54321);
    @(negedge clk); bcd_in = 20'h12345; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", busy === 1'b0, busy, 0);
    check("midrst_done", done === 1'b0, done, 0);
    check("midrst_bin_out", bin_out === 17'd0, bin_out, 0);
    check("midrst_err", err === 1'b0, err, 0);
    check("midrst_ovf", ovf === 1'b0, ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 2*BW; i++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_no_done", nd === 0, nd, 0);
    run_big(20'h12345);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
Iterative BCD-to-binary converter using reverse double-dabble (shift-right, subtract-3). It is the inverse of the team's combinational binary-to-BCD block and sits on display/keypad input paths where packed BCD must return to binary. A start/done handshake processes one operand per conversion. Every step is registered, so the block has no long combinational chain.

Parameters:
- DIGITS, 5, number of packed BCD input digits (4 bits each, digit 0 in bits [3:0]).
- BIN_W, 17, binary result width (17 bits covers 99999).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on clk rising edge.
- start  input  1  request conversion of bcd_in; accepted only in IDLE.
- bcd_in  input  DIGITS*4  packed BCD operand; sampled on the accepting edge only.
- busy  output  1  high while in CONV.
- done  output  1  one-cycle pulse; results valid.
- bin_out  output  BIN_W  binary result; held from done until the next accepted start.
- err  output  1  a digit of the captured operand was >9; valid with done, held.
- ovf  output  1  value does not fit in BIN_W bits; valid with done, held.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, bin_out=0, err=0, ovf=0, internal shift register and counter cleared. This applies mid-conversion; the operand in flight is discarded with no done.
- Internal register sreg width DIGITS*4+BIN_W: upper field = BCD digits, lower field = binary.
- States: IDLE, CONV, DONE.
- IDLE: when start=1 at edge k, load sreg={bcd_in, BIN_W'b0}, set cnt=0, latch err_flag=(any nibble>9), go to CONV. When start=0, stay in IDLE.
- CONV: each edge performs one step. Shift sreg right by 1 (zero fill at MSB). Then, for every BCD digit independently, if the digit is >=8, subtract 3 (4-bit). Increment cnt.
- On the edge completing step BIN_W (edge k+BIN_W), go to DONE and register the outputs:
  - ovf = (BCD field after the final step != 0).
  - bin_out = 0 if err_flag, else the lower BIN_W bits.
  - err = err_flag.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: done is high in the cycle after edge k+BIN_W, i.e. BIN_W+1 clocks after start is sampled. Throughput is one conversion per BIN_W+2 clocks.
- start is ignored in CONV and DONE. It is not queued, and bcd_in changes during CONV have no effect.
- busy=1 only in CONV. busy and done are never high together.
- err and ovf may both be set. When err=1, ovf is computed but bin_out is forced to 0.
- bin_out, err and ovf change only at the DONE entry edge or on reset.

Optional Feature:
- Macro BCD2BIN_FAST_EN.
- Defined: CONV performs two shift/correct steps per clock, and cnt advances by 2. If BIN_W is odd, the final cycle performs a single step. done occurs ceil(BIN_W/2)+1 clocks after start is sampled. Results are bit-identical to the undefined build.
- Undefined: one step per clock, as above.

Test Plan:
- Defaults: bcd_in=20'h00000 -> done at start+18 clocks; bin_out=0, err=0, ovf=0. Then bcd_in=20'h99999 -> bin_out=99999 (17'h1869F).
- bcd_in=20'h00010 -> bin_out=10. bcd_in=20'h12345 -> bin_out=12345. busy high for exactly 17 cycles; done high for exactly 1 cycle.
- bcd_in=20'h000A5 -> err=1, bin_out=0, done at the normal latency. The next operand 20'h00042 -> err=0, bin_out=42.
- DIGITS=3, BIN_W=8: 12'h255 -> bin_out=255, ovf=0. 12'h256 -> ovf=1, bin_out=0 (256 mod 256).
- Hold start=1 continuously with bcd_in changing every cycle -> conversions start only in IDLE, spaced 19 clocks apart. Each result matches the bcd_in sampled at its accepting edge.
- Assert rst_n=0 for 1 cycle, 5 clocks into a conversion -> all outputs 0 and no done pulse. A start on the following cycle converts correctly. With BCD2BIN_FAST_EN defined, 20'h12345 -> bin_out=12345 with done at start+10 clocks.
